// File: rtl/btn_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, debounce FSM, registered edge pulses and count tick.
// Define BTN_DEBOUNCE_AUTOREPEAT_EN to add hold-to-repeat ticks on btn_tick.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_tick
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_repeat
    $error("HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_HI  = 2'd1,
    PRESSED = 2'd2,
    ARM_LO  = 2'd3
  } state_e;

  logic             sync1_q, s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             tick_q, tick_d;

  // NOTE: every signal assigned in always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_q) begin
          state_d = ARM_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      ARM_HI: begin
        if (!s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s_q) begin
          state_d = ARM_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      ARM_LO: begin
        if (s_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // The accepted level only moves on a completed debounce, so both arm states hold it.
    level_d = (state_d == PRESSED) || (state_d == ARM_LO);
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_next, hold_target;
  logic              repeat_q, repeat_d;
  logic              rep_tick;

  // hold_cnt restarts after every tick; repeat_q selects the first-hold or repeat interval.
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    repeat_d    = repeat_q;
    rep_tick    = 1'b0;
    hold_next   = hold_cnt_q + 1'b1;
    hold_target = repeat_q ? HOLD_W'(REPEAT_CYCLES) : HOLD_W'(HOLD_CYCLES);
    if (rise_d || state_q == IDLE || state_q == ARM_HI) begin
      hold_cnt_d = '0;
      repeat_d   = 1'b0;
    end else if (state_q == PRESSED && s_q) begin
      if (hold_next == hold_target) begin
        rep_tick   = 1'b1;
        hold_cnt_d = '0;
        repeat_d   = 1'b1;
      end else begin
        hold_cnt_d = hold_next;
      end
    end
    tick_d = rise_d | rep_tick;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      repeat_q   <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      repeat_q   <= repeat_d;
    end
  end
`else
  assign tick_d = rise_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the 2-FF synchronizer into one stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      s_q     <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      tick_q  <= tick_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;
  assign btn_tick  = tick_q;

endmodule
